apb_sram_ctrl: RTL and testbench

- APB3 slave controller that sequences one single-port synchronous SRAM (simple_sram: 1-cycle registered read, write-priority, dout not updated on write cycles).
- Converts APB setup/access phases into SRAM write strobes and read-address/capture cycles.
- Inserts wait states via pready and flags out-of-range addresses via pslverr.
- Sits between the APB interconnect and the SRAM macro in the APB_SRAM subsystem.

---
 rtl/apb_sram_pkg.sv | 25 ++
 rtl/apb_sram_top.sv | 66 ++++++
 rtl/simple_sram.sv | 41 ++++
 rtl/apb_sram_ctrl.sv | 110 +++++++++++
 tb/tb_apb_sram_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_sram_pkg.sv
// apb_sram_pkg: shared definitions for the APB-to-SRAM controller slice.
//   - state_e     : controller FSM state encoding
//   - *WidthDef   : default data / SRAM address / APB address widths
//   - in_range()  : checks that an APB word address falls inside the SRAM
package apb_sram_pkg;

  localparam int unsigned DataWidthDef    = 8;
  localparam int unsigned AddrWidthDef    = 4;
  localparam int unsigned ApbAddrWidthDef = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdAddr,
    StRdData,
    StErr
  } state_e;

  // True when paddr addresses one of the 2**addr_width SRAM words.
  // Callers zero-extend paddr to 32 bits, so APB address widths up to 32 are supported.
  function automatic logic in_range(input logic [31:0] paddr, input int unsigned addr_width);
    return (paddr >> addr_width) == 32'd0;
  endfunction

endpackage

// File: rtl/apb_sram_top.sv
// apb_sram_top: APB_SRAM subsystem wrapper, controller plus SRAM macro.
//   clk, rst_n            : clock, asynchronous active-low reset
//   psel..pwdata          : APB request
//   prdata/pready/pslverr : APB response
module apb_sram_top
  import apb_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DataWidthDef,
  parameter int unsigned ADDR_WIDTH     = AddrWidthDef,
  parameter int unsigned APB_ADDR_WIDTH = ApbAddrWidthDef
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);

  logic                  sram_wr_en;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;
  logic                  sram_rst;

  // The SRAM macro uses an active-high reset.
  assign sram_rst = ~rst_n;

  apb_sram_ctrl #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .sram_wr_en (sram_wr_en),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  simple_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk   (clk),
    .rst   (sram_rst),
    .wr_en (sram_wr_en),
    .addr  (sram_addr),
    .din   (sram_din),
    .dout  (sram_dout)
  );

endmodule

// File: rtl/simple_sram.sv
// simple_sram: single-port synchronous SRAM model.
//   clk   : clock
//   rst   : synchronous, active-high; clears dout only, contents are kept
//   wr_en : write strobe; write has priority and dout is not updated that cycle
//   addr  : word address
//   din   : write data
//   dout  : registered read data (mem[addr] of the previous non-write cycle)
module simple_sram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (!wr_en) begin
      dout_q <= mem_q[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/apb_sram_ctrl.sv
// apb_sram_ctrl: APB3 slave that sequences one single-port synchronous SRAM.
//   clk, rst_n            : clock, asynchronous active-low reset
//   psel/penable/pwrite   : APB control
//   paddr/pwdata          : APB word address / write data
//   prdata/pready/pslverr : APB response (writes: 0 wait states, reads: 1 wait state,
//                           out-of-range: 0 wait states with pslverr)
//   sram_wr_en/addr/din   : SRAM request, registered
//   sram_dout             : SRAM registered read data
module apb_sram_ctrl
  import apb_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DataWidthDef,
  parameter int unsigned ADDR_WIDTH     = AddrWidthDef,
  parameter int unsigned APB_ADDR_WIDTH = ApbAddrWidthDef  // must be >= ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      sram_wr_en,
  output logic [ADDR_WIDTH-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_din,
  input  logic [DATA_WIDTH-1:0]     sram_dout
);

  state_e                state_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  pready_q;
  logic                  pslverr_q;

  logic setup;
  assign setup = psel && !penable;

  // Outputs for the next state are computed alongside the transition so that pready,
  // pslverr and sram_wr_en come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // penable without a preceding setup phase is ignored here.
          if (setup) begin
            addr_q <= paddr[ADDR_WIDTH-1:0];
            din_q  <= pwdata;
            if (!in_range(32'(paddr), ADDR_WIDTH)) begin
              state_q   <= StErr;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
            end else if (pwrite) begin
              state_q  <= StWr;
              wr_en_q  <= 1'b1;
              pready_q <= 1'b1;
            end else begin
              state_q <= StRdAddr;
            end
          end
        end
        StWr: begin
          state_q <= StIdle;
        end
        StRdAddr: begin
          // Dropping psel here abandons the read without ever raising pready.
          if (psel) begin
            state_q  <= StRdData;
            pready_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StRdData: begin
          state_q <= StIdle;
        end
        StErr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sram_wr_en = wr_en_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;
  assign pready     = pready_q;
  assign pslverr    = pslverr_q;

  // The SRAM read data only becomes valid in the RD_DATA cycle itself, so prdata is a gated
  // pass-through rather than a flop (a flop would add a second wait state).
  assign prdata = (state_q == StRdData) ? sram_dout : '0;

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// tb_apb_sram_ctrl: self-checking bench for apb_sram_ctrl. An SRAM behaviour model is attached
// to the SRAM port, and an array of expected memory contents predicts every APB response.
module tb_apb_sram_ctrl;

  logic       clk;
  logic       rst_n;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       sram_wr_en;
  logic [3:0] sram_addr;
  logic [7:0] sram_din;
  logic [7:0] sram_dout;

  int n_cmp;
  int n_fail;

  logic [7:0] ref_mem [16];  // expected SRAM contents
  logic [7:0] env_mem [16];  // storage of the attached SRAM model

  apb_sram_ctrl #(
    .DATA_WIDTH     (8),
    .ADDR_WIDTH     (4),
    .APB_ADDR_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .sram_wr_en (sram_wr_en),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: one-cycle registered read, write priority, dout held on write cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      sram_dout <= 8'h00;
    end else if (sram_wr_en) begin
      env_mem[sram_addr] <= sram_din;
    end else begin
      sram_dout <= env_mem[sram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus idle for n cycles; the controller must stay silent.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      psel    = 1'b0;
      penable = 1'b0;
      check("idle_pready", pready, 0);
      check("idle_wr_en", sram_wr_en, 0);
    end
  endtask

  // One complete APB transfer. Leaves psel high so a following call is back-to-back.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data);
    bit         exp_err;
    int         exp_waits;
    int         waits;
    logic [7:0] exp_rd;
    exp_err   = (addr >= 8'd16);
    exp_waits = (exp_err || wr) ? 0 : 1;
    exp_rd    = exp_err ? 8'h00 : ref_mem[addr[3:0]];
    // setup phase
    @(posedge clk); #1;
    check("setup_pready", pready, 0);
    check("setup_wr_en", sram_wr_en, 0);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    // access phase
    @(posedge clk); #1;
    penable = 1'b1;
    waits   = 0;
    while (pready !== 1'b1 && waits < 4) begin
      check("wait_wr_en", sram_wr_en, 0);
      waits++;
      @(posedge clk); #1;
    end
    check(wr ? "wr_waits" : "rd_waits", waits, exp_waits);
    check("pslverr", pslverr, exp_err);
    check("wr_strobe", sram_wr_en, (wr && !exp_err) ? 1 : 0);
    if (!wr) check("prdata", prdata, exp_rd);
    if (wr && !exp_err) begin
      check("sram_addr", sram_addr, addr[3:0]);
      check("sram_din", sram_din, data);
      ref_mem[addr[3:0]] = data;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    pwdata  = 8'h00;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

    // Reset state, asserted asynchronously before any clock edge.
    #1;
    check("rst_pready", pready, 0);
    check("rst_pslverr", pslverr, 0);
    check("rst_prdata", prdata, 0);
    check("rst_wr_en", sram_wr_en, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_din", sram_din, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(4);

    // Write then read.
    xfer(1'b1, 8'h03, 8'hA5);
    idle(1);
    xfer(1'b0, 8'h03, 8'h00);
    idle(2);

    // Address sweep.
    for (int a = 0; a < 16; a++) xfer(1'b1, 8'(a), 8'(a) ^ 8'h5A);
    for (int a = 0; a < 16; a++) xfer(1'b0, 8'(a), 8'h00);
    idle(2);

    // Out-of-range write aliasing word 0 must not touch it; out-of-range read.
    xfer(1'b1, 8'h10, 8'h77);
    xfer(1'b0, 8'h00, 8'h00);
    xfer(1'b0, 8'hC7, 8'h00);
    idle(1);

    // Back-to-back.
    xfer(1'b1, 8'h01, 8'h11);
    xfer(1'b0, 8'h01, 8'h00);
    xfer(1'b1, 8'h01, 8'h22);
    xfer(1'b0, 8'h01, 8'h00);
    idle(1);

    // penable without a setup phase is ignored.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'hFF;
    repeat (2) begin
      @(posedge clk); #1;
      check("noset_pready", pready, 0);
      check("noset_wr_en", sram_wr_en, 0);
    end
    idle(1);
    xfer(1'b0, 8'h05, 8'h00);
    idle(1);

    // Abort a read in its access phase.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h02;
    @(posedge clk); #1;
    check("abort_pready0", pready, 0);
    psel = 1'b0; penable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_pready", pready, 0);
      check("abort_pslverr", pslverr, 0);
    end
    xfer(1'b0, 8'h02, 8'h00);
    idle(1);

    // Randomized traffic with random gaps.
    for (int i = 0; i < 80; i++) begin
      bit         wr;
      logic [7:0] a;
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 20));
      if (a == 8'd20) a = 8'($urandom_range(16, 255));
      xfer(wr, a, 8'($urandom));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    // Reset asserted in the RD_DATA cycle of a read.
    xfer(1'b1, 8'h07, 8'hC3);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h07; pwdata = 8'h3C;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_pready", pready, 1);
    check("pre_rst_prdata", prdata, 8'hC3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pready", pready, 0);
    check("mid_rst_pslverr", pslverr, 0);
    check("mid_rst_prdata", prdata, 0);
    check("mid_rst_wr_en", sram_wr_en, 0);
    check("mid_rst_sram_addr", sram_addr, 0);
    check("mid_rst_sram_din", sram_din, 0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle(4);
    // SRAM contents survive controller reset.
    xfer(1'b0, 8'h07, 8'h00);
    xfer(1'b0, 8'h01, 8'h00);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
